// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg
//   Shared pipeline definitions for the EX/MEM stage:
//   ALU opcode constants, ALU flag bit positions, exception cause codes
//   and the trap FSM state encoding.
package ex_mem_stage_pkg;

  // ALU opcodes as presented on alu_con
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // Bit positions inside alu_flag ({underflow, overflow, divzero})
  localparam int FLAG_DIVZ = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_UNF  = 2;

  // Exception cause codes reported on cause
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_DIVZ = 5'd15;

  // Trap FSM: RUN passes instructions, TRAP holds a pending request
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

endpackage

// File: rtl/ex_mem_stage_exc_detect.sv
// exc_detect
//   Combinational fault classifier for the instruction in EX.
//   Ports:
//     alu_con   in  4       ALU opcode
//     alu_flag  in  FLAG_W  ALU flags {underflow, overflow, divzero}
//     ex_valid  in  1       EX holds a real instruction
//     fault     out 1       instruction must trap
//     cause     out 5       exception code (valid when fault=1)
module exc_detect #(
  parameter int FLAG_W = 3
) (
  input  logic [3:0]        alu_con,
  input  logic [FLAG_W-1:0] alu_flag,
  input  logic              ex_valid,
  output logic              fault,
  output logic [4:0]        cause
);
  import ex_mem_stage_pkg::*;

  logic ovf_fault;
  logic divz_fault;

  // Underflow (and anything above it) never traps; multiply overflow is
  // also ignored because only add/sub qualify the overflow flag.
  logic unused_flags;
  assign unused_flags = ^alu_flag[FLAG_W-1:FLAG_UNF];

  assign ovf_fault  = ex_valid && alu_flag[FLAG_OVF] &&
                      ((alu_con == ALU_ADD) || (alu_con == ALU_SUB));
  assign divz_fault = ex_valid && alu_flag[FLAG_DIVZ] && (alu_con == ALU_DIV);

  always_comb begin
    fault = 1'b0;
    cause = 5'd0;
    // Overflow wins when both qualify
    if (ovf_fault) begin
      fault = 1'b1;
      cause = EXC_OV;
    end else if (divz_fault) begin
      fault = 1'b1;
      cause = EXC_DIVZ;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   EX/MEM pipeline register with precise-exception capture.
//   A faulting ALU instruction is replaced by a bubble, its PC and cause are
//   latched into epc/cause, and exc_req is held until exc_ack.
//   Ports:
//     clk, rst_n                          clock, async active-low reset
//     alu_result, alu_flag, alu_con       ALU outputs / opcode
//     ex_valid, ex_pc, ex_store_data      EX instruction info
//     ex_dest, ex_reg_write, ex_mem_read,
//     ex_mem_write, ex_mem_to_reg         EX control
//     stall, flush, exc_ack               hazard / exception control
//     mem_*                               registered pipeline outputs
//     exc_req, epc, cause, exc_count      registered exception outputs
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int FLAG_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flag,
  input  logic [3:0]        alu_con,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_dest,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              stall,
  input  logic              flush,
  input  logic              exc_ack,
  output logic              mem_valid,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [4:0]        mem_dest,
  output logic              exc_req,
  output logic [DATA_W-1:0] epc,
  output logic [4:0]        cause,
  output logic [CNT_W-1:0]  exc_count
);
  import ex_mem_stage_pkg::*;

  state_t state_reg, state_next;

  logic              valid_reg,      valid_next;
  logic              reg_write_reg,  reg_write_next;
  logic              mem_read_reg,   mem_read_next;
  logic              mem_write_reg,  mem_write_next;
  logic              mem_to_reg_reg, mem_to_reg_next;
  logic [DATA_W-1:0] result_reg,     result_next;
  logic [DATA_W-1:0] store_data_reg, store_data_next;
  logic [4:0]        dest_reg,       dest_next;
  logic              exc_req_reg,    exc_req_next;
  logic [DATA_W-1:0] epc_reg,        epc_next;
  logic [4:0]        cause_reg,      cause_next;
  logic [CNT_W-1:0]  count_reg,      count_next;

  logic       fault;
  logic [4:0] fault_cause;
  logic       bubble;
  logic       capture;

  exc_detect #(
    .FLAG_W (FLAG_W)
  ) u_exc_detect (
    .alu_con  (alu_con),
    .alu_flag (alu_flag),
    .ex_valid (ex_valid),
    .fault    (fault),
    .cause    (fault_cause)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_RUN;
      valid_reg      <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      result_reg     <= '0;
      store_data_reg <= '0;
      dest_reg       <= '0;
      exc_req_reg    <= 1'b0;
      epc_reg        <= '0;
      cause_reg      <= '0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      valid_reg      <= valid_next;
      reg_write_reg  <= reg_write_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      mem_to_reg_reg <= mem_to_reg_next;
      result_reg     <= result_next;
      store_data_reg <= store_data_next;
      dest_reg       <= dest_next;
      exc_req_reg    <= exc_req_next;
      epc_reg        <= epc_next;
      cause_reg      <= cause_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    // Default: every register holds (this is also the RUN stall behaviour)
    state_next      = state_reg;
    valid_next      = valid_reg;
    reg_write_next  = reg_write_reg;
    mem_read_next   = mem_read_reg;
    mem_write_next  = mem_write_reg;
    mem_to_reg_next = mem_to_reg_reg;
    result_next     = result_reg;
    store_data_next = store_data_reg;
    dest_next       = dest_reg;
    exc_req_next    = exc_req_reg;
    epc_next        = epc_reg;
    cause_next      = cause_reg;
    count_next      = count_reg;
    bubble          = 1'b0;
    capture         = 1'b0;

    case (state_reg)
      ST_RUN: begin
        // Flush beats stall; faults are only evaluated on a moving stage
        if (flush) begin
          bubble = 1'b1;
        end else if (!stall) begin
          if (fault) begin
            bubble       = 1'b1;
            epc_next     = ex_pc;
            cause_next   = fault_cause;
            exc_req_next = 1'b1;
            if (count_reg != {CNT_W{1'b1}}) begin
              count_next = count_reg + CNT_W'(1);
            end
            state_next   = ST_TRAP;
          end else begin
            capture = 1'b1;
          end
        end
      end
      ST_TRAP: begin
        // Nothing younger than the faulting instruction may reach MEM
        bubble = 1'b1;
        if (exc_ack) begin
          exc_req_next = 1'b0;
          state_next   = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase

    if (bubble) begin
      valid_next      = 1'b0;
      reg_write_next  = 1'b0;
      mem_read_next   = 1'b0;
      mem_write_next  = 1'b0;
      mem_to_reg_next = 1'b0;
      result_next     = '0;
      store_data_next = '0;
      dest_next       = '0;
    end else if (capture) begin
      valid_next      = ex_valid;
      reg_write_next  = ex_reg_write;
      mem_read_next   = ex_mem_read;
      mem_write_next  = ex_mem_write;
      mem_to_reg_next = ex_mem_to_reg;
      result_next     = alu_result;
      store_data_next = ex_store_data;
      dest_next       = ex_dest;
    end
  end

  assign mem_valid      = valid_reg;
  assign mem_reg_write  = reg_write_reg;
  assign mem_mem_read   = mem_read_reg;
  assign mem_mem_write  = mem_write_reg;
  assign mem_mem_to_reg = mem_to_reg_reg;
  assign mem_result     = result_reg;
  assign mem_store_data = store_data_reg;
  assign mem_dest       = dest_reg;
  assign exc_req        = exc_req_reg;
  assign epc            = epc_reg;
  assign cause          = cause_reg;
  assign exc_count      = count_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] alu_result = '0;
  logic [2:0]  alu_flag = '0;
  logic [3:0]  alu_con = '0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_dest = '0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_mem_to_reg = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        exc_ack = 1'b0;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic [31:0] mem_result, mem_store_data;
  logic [4:0]  mem_dest;
  logic        exc_req;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic [7:0]  exc_count;

  int checks = 0;
  int errors = 0;

  ex_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_result     (alu_result),
    .alu_flag       (alu_flag),
    .alu_con        (alu_con),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_store_data  (ex_store_data),
    .ex_dest        (ex_dest),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .stall          (stall),
    .flush          (flush),
    .exc_ack        (exc_ack),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_read   (mem_mem_read),
    .mem_mem_write  (mem_mem_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_result     (mem_result),
    .mem_store_data (mem_store_data),
    .mem_dest       (mem_dest),
    .exc_req        (exc_req),
    .epc            (epc),
    .cause          (cause),
    .exc_count      (exc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs are changed 1 time unit after a rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  // Inputs per row: reg_write=1, mem_to_reg=1, mem_read=0, mem_write=0,
  // store_data=~result. A row whose expected dest is nonzero expects a
  // captured (non-bubble) register, so reg_write/mem_to_reg=1 and
  // store_data=~e_res; otherwise both are 0.
  typedef struct {
    logic [3:0]  con;
    logic [2:0]  flag;
    logic        v, st, fl, ack;
    logic [31:0] pc, res;
    logic [4:0]  dest;
    logic        e_valid;
    logic [31:0] e_res;
    logic [4:0]  e_dest;
    logic        e_req;
    logic [31:0] e_epc;
    logic [4:0]  e_cause;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[23];

  // ---------------- reference model ----------------
  logic        m_trap;
  logic        m_valid, m_rw, m_mr, m_mw, m_mtr, m_req;
  logic [31:0] m_res, m_st, m_epc;
  logic [4:0]  m_dest, m_cause;
  int          m_cnt;

  task automatic model_reset();
    m_trap = 0; m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_req = 0;
    m_res = 0; m_st = 0; m_epc = 0; m_dest = 0; m_cause = 0; m_cnt = 0;
  endtask

  task automatic model_bubble();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0;
    m_res = 0; m_st = 0; m_dest = 0;
  endtask

  // One rising edge worth of behaviour, from the stage's rules.
  task automatic model_edge();
    bit is_ovf, is_divz;
    is_ovf  = ex_valid && alu_flag[1] && (alu_con == 4'd2 || alu_con == 4'd6);
    is_divz = ex_valid && alu_flag[0] && (alu_con == 4'd5);
    if (m_trap) begin
      model_bubble();
      if (exc_ack) begin
        m_req = 0;
        m_trap = 0;
      end
    end else if (flush) begin
      model_bubble();
    end else if (stall) begin
      // everything holds
    end else if (is_ovf || is_divz) begin
      model_bubble();
      m_epc = ex_pc;
      m_cause = is_ovf ? 5'd12 : 5'd15;
      m_req = 1;
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      m_trap = 1;
    end else begin
      m_valid = ex_valid; m_rw = ex_reg_write; m_mr = ex_mem_read;
      m_mw = ex_mem_write; m_mtr = ex_mem_to_reg;
      m_res = alu_result; m_st = ex_store_data; m_dest = ex_dest;
    end
  endtask

  task automatic check_model(input int n);
    chk("rnd_valid", mem_valid, m_valid);
    chk("rnd_reg_write", mem_reg_write, m_rw);
    chk("rnd_mem_read", mem_mem_read, m_mr);
    chk("rnd_mem_write", mem_mem_write, m_mw);
    chk("rnd_mem_to_reg", mem_mem_to_reg, m_mtr);
    chk("rnd_result", mem_result, m_res);
    chk("rnd_store", mem_store_data, m_st);
    chk("rnd_dest", mem_dest, m_dest);
    chk("rnd_exc_req", exc_req, m_req);
    chk("rnd_epc", epc, m_epc);
    chk("rnd_cause", cause, m_cause);
    chk("rnd_count", exc_count, m_cnt[7:0]);
    $display("rnd %0d con=%b flag=%b v=%b st=%b fl=%b ack=%b -> valid=%b res=%h req=%b cause=%0d cnt=%0d",
             n, alu_con, alu_flag, ex_valid, stall, flush, exc_ack,
             mem_valid, mem_result, exc_req, cause, exc_count);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_in(input logic [3:0] con, input logic [2:0] flag, input logic v,
                        input logic st, input logic fl, input logic ack,
                        input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest);
    alu_con = con; alu_flag = flag; ex_valid = v; stall = st; flush = fl; exc_ack = ack;
    ex_pc = pc; alu_result = res; ex_store_data = ~res; ex_dest = dest;
    ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'd2, 3'b000, 1, 0, 0, 0, 32'h100,      32'h5,    5'd3,  1, 32'h5,    5'd3, 0, 32'h0,        5'd0,  8'd0};
    vecs[1]  = '{4'd2, 3'b010, 1, 0, 0, 0, 32'h00400010, 32'h7,    5'd4,  0, 32'h0,    5'd0, 1, 32'h00400010, 5'd12, 8'd1};
    vecs[2]  = '{4'd2, 3'b000, 1, 0, 0, 0, 32'h104,      32'h9,    5'd4,  0, 32'h0,    5'd0, 1, 32'h00400010, 5'd12, 8'd1};
    vecs[3]  = '{4'd2, 3'b000, 1, 0, 0, 0, 32'h104,      32'h9,    5'd4,  0, 32'h0,    5'd0, 1, 32'h00400010, 5'd12, 8'd1};
    vecs[4]  = '{4'd2, 3'b000, 1, 0, 0, 0, 32'h104,      32'h9,    5'd4,  0, 32'h0,    5'd0, 1, 32'h00400010, 5'd12, 8'd1};
    vecs[5]  = '{4'd2, 3'b000, 1, 0, 0, 1, 32'h104,      32'h9,    5'd4,  0, 32'h0,    5'd0, 0, 32'h00400010, 5'd12, 8'd1};
    vecs[6]  = '{4'd6, 3'b011, 1, 0, 0, 0, 32'h200,      32'h11,   5'd5,  0, 32'h0,    5'd0, 1, 32'h200,      5'd12, 8'd2};
    vecs[7]  = '{4'd6, 3'b000, 1, 0, 0, 1, 32'h204,      32'h12,   5'd5,  0, 32'h0,    5'd0, 0, 32'h200,      5'd12, 8'd2};
    vecs[8]  = '{4'd5, 3'b001, 1, 0, 0, 0, 32'h300,      32'h13,   5'd6,  0, 32'h0,    5'd0, 1, 32'h300,      5'd15, 8'd3};
    vecs[9]  = '{4'd2, 3'b000, 1, 1, 0, 1, 32'h304,      32'h14,   5'd6,  0, 32'h0,    5'd0, 0, 32'h300,      5'd15, 8'd3};
    vecs[10] = '{4'd3, 3'b010, 1, 0, 0, 0, 32'h400,      32'h1234, 5'd7,  1, 32'h1234, 5'd7, 0, 32'h300,      5'd15, 8'd3};
    vecs[11] = '{4'd2, 3'b010, 1, 1, 0, 0, 32'h500,      32'h55,   5'd8,  1, 32'h1234, 5'd7, 0, 32'h300,      5'd15, 8'd3};
    vecs[12] = '{4'd2, 3'b010, 1, 0, 0, 0, 32'h500,      32'h55,   5'd8,  0, 32'h0,    5'd0, 1, 32'h500,      5'd12, 8'd4};
    vecs[13] = '{4'd2, 3'b000, 1, 0, 0, 1, 32'h504,      32'h56,   5'd8,  0, 32'h0,    5'd0, 0, 32'h500,      5'd12, 8'd4};
    vecs[14] = '{4'd2, 3'b000, 1, 0, 0, 0, 32'h508,      32'h66,   5'd2,  1, 32'h66,   5'd2, 0, 32'h500,      5'd12, 8'd4};
    vecs[15] = '{4'd2, 3'b000, 1, 1, 1, 0, 32'h50c,      32'h77,   5'd2,  0, 32'h0,    5'd0, 0, 32'h500,      5'd12, 8'd4};
    vecs[16] = '{4'd2, 3'b010, 1, 0, 1, 0, 32'h600,      32'h78,   5'd2,  0, 32'h0,    5'd0, 0, 32'h500,      5'd12, 8'd4};
    vecs[17] = '{4'd2, 3'b010, 0, 0, 0, 0, 32'h700,      32'h88,   5'd1,  0, 32'h88,   5'd1, 0, 32'h500,      5'd12, 8'd4};
    vecs[18] = '{4'd2, 3'b000, 1, 0, 0, 1, 32'h704,      32'h99,   5'd5,  1, 32'h99,   5'd5, 0, 32'h500,      5'd12, 8'd4};
    vecs[19] = '{4'd5, 3'b110, 1, 0, 0, 0, 32'h708,      32'haa,   5'd6,  1, 32'haa,   5'd6, 0, 32'h500,      5'd12, 8'd4};
    vecs[20] = '{4'd2, 3'b100, 1, 0, 0, 0, 32'h70c,      32'hbb,   5'd9,  1, 32'hbb,   5'd9, 0, 32'h500,      5'd12, 8'd4};
    vecs[21] = '{4'd6, 3'b010, 1, 0, 0, 0, 32'h710,      32'hcc,   5'd10, 0, 32'h0,    5'd0, 1, 32'h710,      5'd12, 8'd5};
    vecs[22] = '{4'd2, 3'b000, 1, 0, 0, 1, 32'h714,      32'hdd,   5'd10, 0, 32'h0,    5'd0, 0, 32'h710,      5'd12, 8'd5};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid", mem_valid, 1'b0);
    chk("reset_result", mem_result, 32'h0);
    chk("reset_req", exc_req, 1'b0);
    chk("reset_count", exc_count, 8'h0);
    tick();
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 23; i++) begin
      set_in(vecs[i].con, vecs[i].flag, vecs[i].v, vecs[i].st, vecs[i].fl, vecs[i].ack,
             vecs[i].pc, vecs[i].res, vecs[i].dest);
      tick();
      chk($sformatf("vec%0d_valid", i), mem_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_result", i), mem_result, vecs[i].e_res);
      chk($sformatf("vec%0d_dest", i), mem_dest, vecs[i].e_dest);
      chk($sformatf("vec%0d_reg_write", i), mem_reg_write, vecs[i].e_dest != 0);
      chk($sformatf("vec%0d_mem_to_reg", i), mem_mem_to_reg, vecs[i].e_dest != 0);
      chk($sformatf("vec%0d_store", i), mem_store_data, (vecs[i].e_dest != 0) ? ~vecs[i].e_res : 32'h0);
      chk($sformatf("vec%0d_req", i), exc_req, vecs[i].e_req);
      chk($sformatf("vec%0d_epc", i), epc, vecs[i].e_epc);
      chk($sformatf("vec%0d_cause", i), cause, vecs[i].e_cause);
      chk($sformatf("vec%0d_count", i), exc_count, vecs[i].e_cnt);
      $display("vec %0d con=%b flag=%b v=%b st=%b fl=%b ack=%b -> valid=%b res=%h dest=%0d req=%b epc=%h cause=%0d cnt=%0d",
               i, vecs[i].con, vecs[i].flag, vecs[i].v, vecs[i].st, vecs[i].fl, vecs[i].ack,
               mem_valid, mem_result, mem_dest, exc_req, epc, cause, exc_count);
    end

    // Asynchronous reset in the middle of a trap
    set_in(4'd2, 3'b010, 1, 0, 0, 0, 32'h900, 32'h1, 5'd1);
    tick();
    chk("midtrap_req_before", exc_req, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("midtrap_req", exc_req, 1'b0);
    chk("midtrap_epc", epc, 32'h0);
    chk("midtrap_cause", cause, 5'd0);
    chk("midtrap_count", exc_count, 8'h0);
    chk("midtrap_valid", mem_valid, 1'b0);
    $display("async reset mid-trap -> req=%b epc=%h cause=%0d cnt=%0d", exc_req, epc, cause, exc_count);
    tick();
    rst_n = 1'b1;
    set_in(4'd2, 3'b000, 1, 0, 0, 0, 32'h904, 32'h42, 5'd4);
    tick();
    chk("postrst_valid", mem_valid, 1'b1);
    chk("postrst_result", mem_result, 32'h42);
    set_in(4'd6, 3'b010, 1, 0, 0, 0, 32'h908, 32'h43, 5'd4);
    tick();
    chk("postrst_fault_req", exc_req, 1'b1);
    chk("postrst_fault_epc", epc, 32'h908);
    chk("postrst_fault_count", exc_count, 8'd1);
    $display("post-reset fault -> req=%b epc=%h cnt=%0d", exc_req, epc, exc_count);

    // Counter saturation: 257 acknowledged faults from a fresh reset
    do_reset();
    for (int n = 1; n <= 257; n++) begin
      set_in(4'd5, 3'b001, 1, 0, 0, 0, 32'h1000 + 32'(n), 32'h0, 5'd2);
      tick();
      chk($sformatf("sat%0d_count", n), exc_count, (n > 255) ? 8'hff : 8'(n));
      chk($sformatf("sat%0d_req", n), exc_req, 1'b1);
      set_in(4'd2, 3'b000, 1, 0, 0, 1, 32'h0, 32'h0, 5'd2);
      tick();
      chk($sformatf("sat%0d_ack", n), exc_req, 1'b0);
      if (n >= 254) $display("sat %0d -> cnt=%0d", n, exc_count);
    end

    // Randomized run against the reference model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(4, 0))
        0: alu_con = 4'd2;
        1: alu_con = 4'd3;
        2: alu_con = 4'd5;
        3: alu_con = 4'd6;
        default: alu_con = 4'($urandom);
      endcase
      alu_flag      = 3'($urandom);
      ex_valid      = ($urandom_range(3, 0) != 0);
      stall         = ($urandom_range(5, 0) == 0);
      flush         = ($urandom_range(7, 0) == 0);
      exc_ack       = ($urandom_range(2, 0) == 0);
      ex_pc         = $urandom;
      alu_result    = $urandom;
      ex_store_data = $urandom;
      ex_dest       = 5'($urandom);
      ex_reg_write  = 1'($urandom);
      ex_mem_read   = 1'($urandom);
      ex_mem_write  = 1'($urandom);
      ex_mem_to_reg = 1'($urandom);
      model_edge();
      tick();
      check_model(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage that registers the execute-stage ALU result, flags and control bits for the memory stage. It also converts ALU arithmetic flags into precise exceptions: it suppresses the faulting instruction, captures EPC and cause, and holds a trap request until the hazard/exception controller acknowledges it. It sits directly downstream of the ALU and upstream of data memory and the MEM/WB register.

## Interface
- `DATA_W`, 32, datapath width (result, PC, store data).
- `FLAG_W`, 3, ALU flag width, ordered {underflow, overflow, divzero}.
- `CNT_W`, 8, width of the saturating exception counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_result`  in  DATA_W  ALU Result.
- `alu_flag`  in  FLAG_W  ALU Flag.
- `alu_con`  in  4  ALU opcode of the instruction in EX (0010 add, 0011 mul, 0101 div, 0110 sub).
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_pc`  in  DATA_W  PC of the EX instruction.
- `ex_store_data`  in  DATA_W  rt operand for stores.
- `ex_dest`  in  5  destination register.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`  in  1 each  control bits.
- `stall`  in  1  hold the stage.
- `flush`  in  1  squash the incoming instruction.
- `exc_ack`  in  1  controller has taken the trap.
- `mem_valid`, `mem_reg_write`, `mem_mem_read`, `mem_mem_write`, `mem_mem_to_reg`  out  1 each  registered control.
- `mem_result`, `mem_store_data`  out  DATA_W  registered data.
- `mem_dest`  out  5  registered destination.
- `exc_req`  out  1  trap request, held until acknowledged.
- `epc`  out  DATA_W  PC of the faulting instruction.
- `cause`  out  5  exception code.
- `exc_count`  out  CNT_W  saturating count of exceptions raised.

## Operation
- FSM states: RUN, TRAP. Reset state is RUN.
- Fault detection applies only in RUN, with `ex_valid`=1, `stall`=0 and `flush`=0:
  - Overflow fault: `alu_flag[1]`=1 and `alu_con` is 0010 or 0110. Cause is 5'd12.
  - Divide-by-zero fault: `alu_flag[0]`=1 and `alu_con`=0101. Cause is 5'd15.
  - Overflow takes priority over divide-by-zero.
  - Underflow (`alu_flag[2]`) and the multiply flag are ignored.
- Normal capture (RUN, no fault, no stall, no flush): all `mem_*` outputs take their EX inputs, and `mem_valid` takes `ex_valid`.
- On a fault:
  - The stage loads a bubble: `mem_valid` and all four `mem_*` control bits go to 0, and data outputs go to 0.
  - `epc` takes `ex_pc` and `cause` takes the code above.
  - `exc_req` goes to 1, `exc_count` increments and saturates at all-ones, and the FSM goes to TRAP.
- In TRAP:
  - The stage loads a bubble every cycle, regardless of inputs.
  - `exc_req` stays at 1, and `epc`/`cause` are frozen.
  - When `exc_ack`=1, `exc_req` clears and the FSM returns to RUN on that edge.
  - `exc_ack` is honoured even when `stall`=1.
- Stall (RUN): all registers hold and no fault is evaluated.
- Flush (RUN): the stage loads a bubble and no fault is raised. When `flush` and `stall` are both 1, flush wins.
- `exc_ack` while in RUN is ignored.

## Timing
- Latency: one cycle from EX inputs to `mem_*` outputs.
- `exc_req`, `epc` and `cause` are visible in the cycle after the faulting instruction leaves EX.
- Minimum TRAP duration is one cycle, which occurs when `exc_ack` is high on the first TRAP edge.
- Reset is asynchronous: assertion immediately zeroes every output, including `exc_count`, `epc`, `cause` and `exc_req`, and forces RUN.
- Reset asserted mid-TRAP drops the pending request with no acknowledge required.
- The first edge after `rst_n` deasserts is a normal RUN edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared pipeline package holds:
  - ALU opcode constants (ALU_ADD, ALU_MUL, ALU_DIV, ALU_SUB).
  - Flag bit indices (FLAG_DIVZ=0, FLAG_OVF=1, FLAG_UNF=2).
  - Cause codes (EXC_OV=12, EXC_DIVZ=15).
  - The FSM state encoding.
- One sub-module is natural: `exc_detect`, combinational. It maps `alu_con`, `alu_flag` and `ex_valid` to a fault bit and a cause code.
- The top module holds the FSM, the pipeline register, EPC/cause and the counter.

## Test plan
- Normal flow: add with result 0x0000_0005, flag 000, dest 3, reg_write=1 -> next cycle `mem_result`=5, `mem_dest`=3, `mem_reg_write`=1, `exc_req`=0.
- Add overflow: alu_con 0010, flag 010, pc 0x0040_0010 -> next cycle bubble, `exc_req`=1, `epc`=0x0040_0010, `cause`=12, `exc_count`=1. `exc_req` holds for 3 cycles with ack low and clears on the ack edge.
- Priority and divide-by-zero:
  - alu_con 0110 with flag 011 -> `cause`=12.
  - After ack, alu_con 0101 with flag 001 -> `cause`=15.
  - alu_con 0011 with flag 010 -> no trap.
- Stall/flush:
  - `stall`=1 while an overflowing add is in EX -> outputs hold and no trap. Releasing stall then raises the trap.
  - `stall`=1 and `flush`=1 together -> bubble.
  - `flush`=1 with an overflowing add -> bubble with no trap.
- Reset and saturation:
  - Assert `rst_n`=0 mid-TRAP between edges -> all outputs 0 immediately and state RUN.
  - 256 acknowledged faults with CNT_W=8 -> `exc_count` stays at 0xFF.
